bus_decoder: RTL
================

# bus_decoder

Parametrised single-master bus decoder with N slave ports between the `furv` core's data port (cyc/we/sel/addr/data/ack) and the memory-mapped peripherals (ram, led, uart). It replaces open-coded strobe equations and OR-merged acks with a table-driven address map. It adds behaviour the open-coded version lacks:

- a registered per-transaction slave select;
- a bus-error response for unmapped addresses;
- a watchdog timeout for slaves that never ack;
- master-abort handling.

## Interface

Parameters:
- `N_SLAVES`, 4: number of slave ports.
- `BASE`, {32'h800, 32'h408, 32'h404, 32'h400}: flattened byte base addresses. Slave i occupies `[32*i+31:32*i]`; index 0 = led, 1 = uart_tx, 2 = uart_rx, 3 = ram.
- `SIZE_LOG2`, {6'd10, 6'd2, 6'd2, 6'd2}: flattened log2 byte size per slave, 6 bits each. `BASE` must be aligned to the size.
- `TIMEOUT`, 255: number of WAIT cycles without ack before an error is returned (1..65535).
- `ERR_DATA`, 32'hDEADBEEF: read data returned on error.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `m_cyc` in 1: master cycle request.
- `m_we` in 1: write enable.
- `m_addr` in 30: word address.
- `m_sel` in 4: byte lanes.
- `m_wdata` in 32: write data.
- `m_rdata` out 32: read data to the master.
- `m_ack` out 1: transaction complete, one-cycle pulse.
- `m_err` out 1: bus error, one-cycle pulse.
- `s_cyc` out 1: cycle to slaves.
- `s_stb` out N_SLAVES: one-hot slave strobe.
- `s_we`, `s_addr`, `s_sel`, `s_wdata` out 1/30/4/32: registered broadcast copies of the master fields.
- `s_rdata` in 32*N_SLAVES: flattened slave read data.
- `s_ack` in N_SLAVES: slave acks.

## Operation

- Decode uses the byte address `{m_addr,2'b00}`. Slave i matches when `(addr >> SIZE_LOG2[i]) == (BASE[i] >> SIZE_LOG2[i])`. On overlap, the lowest index wins.
- FSM states are IDLE, WAIT, RESP.
- IDLE, `m_cyc`=1 with a match:
  - latch the index;
  - register `s_we`, `s_addr`, `s_sel`, `s_wdata`;
  - assert `s_cyc` and `s_stb[idx]`;
  - clear the timeout counter;
  - go to WAIT.
- IDLE, `m_cyc`=1 with no match: go to RESP with the error flag set. No slave strobe is issued.
- WAIT, `s_ack[idx]`=1:
  - latch `s_rdata[idx]` (latched on writes too);
  - drop `s_stb`/`s_cyc`;
  - go to RESP with the ok flag.
- Acks from non-selected slaves are ignored.
- WAIT, counter reaches `TIMEOUT`: drop the strobe and go to RESP with the error flag.
- WAIT, `m_cyc`=0 (abort): drop the strobe and go to IDLE. No `m_ack`/`m_err` is produced.
- Abort, ack and timeout in the same cycle: priority is abort > ack > timeout.
- RESP:
  - assert exactly one of `m_ack` (ok) or `m_err` (error) for one cycle;
  - `m_rdata` = latched data on ok, `ERR_DATA` on error;
  - unconditionally go to IDLE.
- Master contract: a `m_cyc` seen in IDLE always starts a new transaction. The master must drop `m_cyc` or present the next address in the cycle after `m_ack`/`m_err`.
- Reset:
  - all outputs go to 0 (`m_rdata`=0, `s_stb`=0, `s_cyc`=0, `m_ack`=`m_err`=0);
  - the FSM goes to IDLE and the counter clears;
  - reset mid-WAIT drops the strobe on the next edge without a response.

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- Mapped access: `m_cyc` sampled at edge 0 → `s_stb` high from edge 1. `s_ack` first sampled at edge k → strobe low and `m_ack` high from edge k+1, for one cycle.
- For a slave that acks one cycle after its strobe: `m_ack` follows `m_cyc` by 3 cycles.
- Unmapped access: `m_err` is high in the cycle after `m_cyc` is sampled.
- Timeout: `m_err` goes high `TIMEOUT`+1 cycles after `s_stb` rises.
- The counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.
- Throughput: at most one transaction per 3 cycles.

## Structure

- Package `bus_pkg`:
  - `bus_state_t` enum (IDLE, WAIT, RESP);
  - `BUS_ERR_DATA` default;
  - `BUS_ADDR_W`=30, `BUS_DATA_W`=32.
- Sub-module `bus_addr_match`: combinational, one instance per slave, taking base and size_log2 and producing a hit. A priority encoder in `bus_decoder` picks the index.

## Test plan

- Write 32'h0000_002A to byte 0x400 (led) → `s_stb`=4'b0001, `s_wdata`=32'h2A; one `m_ack`, no `m_err`.
- Read from 0x8F0 (ram) with a slave returning 32'h1234_5678 one cycle after strobe → `s_stb`=4'b1000, `s_addr`=30'h23C; `m_ack` 3 cycles after `m_cyc`, `m_rdata`=32'h1234_5678.
- Read from 0x000 (unmapped) → no strobe; `m_err` the next cycle; `m_rdata`=32'hDEADBEEF.
- `TIMEOUT`=4, slave never acks → strobe held 5 cycles, then `m_err`; FSM back in IDLE.
- Drop `m_cyc` 2 cycles into WAIT, with a stray `s_ack[0]` during a ram access → strobe drops, no `m_ack`/`m_err`, stray ack ignored.
- Assert `rst` mid-WAIT → next cycle all outputs 0; a following access to 0x404 completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the furv data-port bus decoder.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 30;
    localparam int unsigned BUS_DATA_W = 32;

    localparam logic [BUS_DATA_W-1:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } bus_state_t;

endpackage

// File: rtl/bus_addr_match.sv
// Combinational address window compare for one slave: hits when the byte address
// lies inside the size-aligned region starting at BASE.
module bus_addr_match
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h0,
    parameter logic [5:0]  SIZE_LOG2 = 6'd2
) (
    input  logic [BUS_ADDR_W-1:0] i_addr,
    output logic                  o_hit
);

    logic [31:0] w_byte_addr;

    assign w_byte_addr = {i_addr, 2'b00};
    assign o_hit       = (w_byte_addr >> SIZE_LOG2) == (BASE >> SIZE_LOG2);

endmodule

// File: rtl/bus_decoder.sv
// Single-master to N-slave bus decoder with registered slave select, bus error on
// unmapped addresses, ack watchdog and master-abort handling.
module bus_decoder
    import bus_pkg::*;
#(
    parameter int unsigned            N_SLAVES  = 4,
    parameter logic [32*N_SLAVES-1:0] BASE      = {32'h800, 32'h408, 32'h404, 32'h400},
    parameter logic [6*N_SLAVES-1:0]  SIZE_LOG2 = {6'd10, 6'd2, 6'd2, 6'd2},
    parameter int unsigned            TIMEOUT   = 255,
    parameter logic [BUS_DATA_W-1:0]  ERR_DATA  = BUS_ERR_DATA
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_cyc,
    input  logic                             m_we,
    input  logic [BUS_ADDR_W-1:0]            m_addr,
    input  logic [3:0]                       m_sel,
    input  logic [BUS_DATA_W-1:0]            m_wdata,
    output logic [BUS_DATA_W-1:0]            m_rdata,
    output logic                             m_ack,
    output logic                             m_err,
    output logic                             s_cyc,
    output logic [N_SLAVES-1:0]              s_stb,
    output logic                             s_we,
    output logic [BUS_ADDR_W-1:0]            s_addr,
    output logic [3:0]                       s_sel,
    output logic [BUS_DATA_W-1:0]            s_wdata,
    input  logic [BUS_DATA_W*N_SLAVES-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]              s_ack
);

    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [N_SLAVES-1:0]   w_hit;
    logic                  w_match;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_sel_ack;
    logic [BUS_DATA_W-1:0] w_sel_rdata;

    bus_state_t            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_s_cyc;
    logic [N_SLAVES-1:0]   r_s_stb;
    logic                  r_s_we;
    logic [BUS_ADDR_W-1:0] r_s_addr;
    logic [3:0]            r_s_sel;
    logic [BUS_DATA_W-1:0] r_s_wdata;
    logic [BUS_DATA_W-1:0] r_m_rdata;
    logic                  r_m_ack;
    logic                  r_m_err;

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_match
        bus_addr_match #(
            .BASE      (BASE[32*g +: 32]),
            .SIZE_LOG2 (SIZE_LOG2[6*g +: 6])
        ) u_match (
            .i_addr (m_addr),
            .o_hit  (w_hit[g])
        );
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_match = 1'b0;
        w_idx   = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_match = 1'b1;
                w_idx   = IDX_W'(i);
            end
        end
    end

    assign w_sel_ack   = s_ack[r_idx];
    assign w_sel_rdata = s_rdata[BUS_DATA_W*r_idx +: BUS_DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_s_cyc   <= 1'b0;
            r_s_stb   <= '0;
            r_s_we    <= 1'b0;
            r_s_addr  <= '0;
            r_s_sel   <= '0;
            r_s_wdata <= '0;
            r_m_rdata <= '0;
            r_m_ack   <= 1'b0;
            r_m_err   <= 1'b0;
        end else begin
            r_m_ack <= 1'b0;
            r_m_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (m_cyc) begin
                        if (w_match) begin
                            r_idx     <= w_idx;
                            r_s_we    <= m_we;
                            r_s_addr  <= m_addr;
                            r_s_sel   <= m_sel;
                            r_s_wdata <= m_wdata;
                            r_s_cyc   <= 1'b1;
                            r_s_stb   <= N_SLAVES'(1) << w_idx;
                            r_cnt     <= '0;
                            r_state   <= WAIT;
                        end else begin
                            r_m_err   <= 1'b1;
                            r_m_rdata <= ERR_DATA;
                            r_state   <= RESP;
                        end
                    end
                end
                WAIT: begin
                    // Abort beats ack beats timeout.
                    if (!m_cyc) begin
                        r_s_cyc <= 1'b0;
                        r_s_stb <= '0;
                        r_state <= IDLE;
                    end else if (w_sel_ack) begin
                        r_s_cyc   <= 1'b0;
                        r_s_stb   <= '0;
                        r_m_rdata <= w_sel_rdata;
                        r_m_ack   <= 1'b1;
                        r_state   <= RESP;
                    end else if (r_cnt == CNT_MAX) begin
                        r_s_cyc   <= 1'b0;
                        r_s_stb   <= '0;
                        r_m_rdata <= ERR_DATA;
                        r_m_err   <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_rdata = r_m_rdata;
    assign m_ack   = r_m_ack;
    assign m_err   = r_m_err;
    assign s_cyc   = r_s_cyc;
    assign s_stb   = r_s_stb;
    assign s_we    = r_s_we;
    assign s_addr  = r_s_addr;
    assign s_sel   = r_s_sel;
    assign s_wdata = r_s_wdata;

endmodule
